// File: rtl/imem_boot_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write/status outputs of the boot loader.
// master = stream source / observer side, slave = the loader.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
           cpu_rst_hold, load_done, load_error
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
           cpu_rst_hold, load_done, load_error
  );

endinterface

// File: rtl/imem_boot_loader_packer.sv
// Packs little-endian bytes into a 32-bit word; o_word_vld fires in the same cycle
// the final byte (index i_last_idx) is accepted. i_clear drops any partial word.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte_dat,
  input  logic [1:0]  i_last_idx,
  output logic        o_word_vld,
  output logic [31:0] o_word_dat
);

  logic [1:0]  r_cnt;
  logic [23:0] r_bytes;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt   <= '0;
      r_bytes <= '0;
    end else if (i_byte_vld) begin
      r_bytes <= {i_byte_dat, r_bytes[23:8]};
      r_cnt   <= (r_cnt == i_last_idx) ? 2'd0 : r_cnt + 2'd1;
    end
  end

  assign o_word_vld = i_byte_vld && (r_cnt == i_last_idx);
  assign o_word_dat = {i_byte_dat, r_bytes};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> header word count -> LE words written to imem; core held in reset until DONE.
// Optional trailing 32-bit checksum of the data words when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = ST_CSUM;
`else
  localparam state_e AFTER_DATA = ST_DONE;
`endif

  state_e                r_state;
  state_e                w_next;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_hold;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         r_cnt;
  logic                  w_accept;
  logic                  w_word_vld;
  logic [31:0]           w_word;
  logic [1:0]            w_last_idx;
  logic                  w_last_data;
  logic                  w_clear;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif

  assign w_accept    = bus.byte_valid && r_ready;
  assign w_last_idx  = (r_state == ST_HDR) ? 2'(HDR_BYTES - 1) : 2'(WORD_BYTES - 1);
  assign w_last_data = (r_cnt == r_n - CW'(1));
  // Any state change discards partially packed bytes.
  assign w_clear     = (w_next != r_state);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_byte_vld (w_accept),
    .i_byte_dat (bus.byte_data),
    .i_last_idx (w_last_idx),
    .o_word_vld (w_word_vld),
    .o_word_dat (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HDR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HDR: begin
        if (w_word_vld) begin
          if (w_word == 32'd0)                w_next = AFTER_DATA;
          else if (w_word > 32'(MAX_WORDS))   w_next = ST_ERROR;
          else                                w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_word_vld && w_last_data) w_next = AFTER_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_word_vld) w_next = (w_word == r_sum) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE:  w_next = ST_DONE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_n     <= '0;
      r_cnt   <= '0;
    end else begin
      r_ready <= (w_next == ST_HDR) || (w_next == ST_LOAD) || (w_next == ST_CSUM);
      // Release lags DONE entry by a cycle so the final write is already visible.
      r_hold  <= (r_state != ST_DONE);
      r_we    <= 1'b0;
      if (r_state == ST_HDR && w_word_vld) begin
        r_n   <= w_word[CW-1:0];
        r_cnt <= '0;
      end
      if (r_state == ST_LOAD && w_word_vld) begin
        r_we    <= 1'b1;
        r_addr  <= r_cnt[ADDR_WIDTH-1:0];
        r_wdata <= w_word;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_HDR) r_sum <= '0;
    else if (r_state == ST_LOAD && w_word_vld) r_sum <= r_sum + w_word;
  end
`endif

  assign bus.byte_ready   = r_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_rst_hold = r_hold;
  assign bus.load_done    = (r_state == ST_DONE);
  assign bus.load_error   = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: programs built as byte queues, expected writes/status from a stream-level model.
module tb_imem_boot_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1024;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   stalled;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0]  prog[$];
  logic [31:0] run_sum;
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  logic        obs_hold[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done, exp_err;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.imem_we === 1'b1) begin
      obs_addr.push_back(int'(bus.imem_addr));
      obs_data.push_back(bus.imem_wdata);
      obs_cyc.push_back(cyc);
      obs_hold.push_back(bus.cpu_rst_hold);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream-level reference: parse header, form LE words, apply optional checksum rule.
  task automatic model();
    logic [31:0] nw, w, sum, cs;
    exp_addr.delete(); exp_data.delete();
    sum = 0;
    nw  = {prog[3], prog[2], prog[1], prog[0]};
    if (nw > 32'(MAXW)) begin
      exp_err = 1; exp_done = 0;
      return;
    end
    for (int k = 0; k < int'(nw); k++) begin
      w = {prog[4+4*k+3], prog[4+4*k+2], prog[4+4*k+1], prog[4+4*k]};
      exp_addr.push_back(k % (1 << AW));
      exp_data.push_back(w);
      sum += w;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    cs = {prog[4+4*nw+3], prog[4+4*nw+2], prog[4+4*nw+1], prog[4+4*nw]};
    exp_done = (cs == sum);
    exp_err  = !exp_done;
`else
    cs = sum;
    exp_done = (cs == sum);
    exp_err  = 0;
`endif
  endtask

  task automatic push_word(input logic [31:0] w);
    prog.push_back(w[7:0]);  prog.push_back(w[15:8]);
    prog.push_back(w[23:16]); prog.push_back(w[31:24]);
  endtask

  task automatic start_prog(input logic [31:0] n);
    prog.delete();
    run_sum = 0;
    push_word(n);
  endtask

  task automatic push_data(input logic [31:0] w);
    push_word(w);
    run_sum += w;
  endtask

  task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(run_sum);
`endif
  endtask

  task automatic add_bad_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(run_sum + 32'd1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; bus.byte_valid = 0; bus.byte_data = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); obs_hold.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(negedge clk);
    bus.byte_valid = 1; bus.byte_data = b;
    w = 0;
    while (bus.byte_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++; errors++; stalled = 1;
      $display("FAIL send_byte: byte_ready never rose (got %b, need 1)", bus.byte_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_prog(input int count, input int gap_max);
    stalled = 0;
    for (int i = 0; i < count && !stalled; i++) begin
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        repeat (g) begin @(negedge clk); bus.byte_valid = 0; end
      end
      send_byte(prog[i]);
    end
    @(negedge clk);
    bus.byte_valid = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; bus.byte_valid = 0; bus.byte_data = 0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.byte_ready !== 1'b0)    begin errors++; $display("FAIL reset ready: got %b need 0", bus.byte_ready); end
    if (bus.imem_we !== 1'b0)       begin errors++; $display("FAIL reset we: got %b need 0", bus.imem_we); end
    if (bus.imem_addr !== '0)       begin errors++; $display("FAIL reset addr: got %h need 0", bus.imem_addr); end
    if (bus.imem_wdata !== 32'd0)   begin errors++; $display("FAIL reset wdata: got %h need 0", bus.imem_wdata); end
    if (bus.cpu_rst_hold !== 1'b1)  begin errors++; $display("FAIL reset hold: got %b need 1", bus.cpu_rst_hold); end
    if (bus.load_done !== 1'b0)     begin errors++; $display("FAIL reset done: got %b need 0", bus.load_done); end
    if (bus.load_error !== 1'b0)    begin errors++; $display("FAIL reset error: got %b need 0", bus.load_error); end
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL ready after reset: got %b need 1", bus.byte_ready); end
  endtask

  task automatic test_directed();
    do_reset();
    start_prog(2); push_data(32'h0000_0013); push_data(32'h0010_0093); add_csum();
    send_prog(prog.size(), 0);
    checks += 6;
    if (obs_addr.size() != 2) begin
      errors++; $display("FAIL directed count: got %0d writes need 2", obs_addr.size());
    end else begin
      if (obs_addr[0] != 0 || obs_data[0] !== 32'h0000_0013) begin errors++; $display("FAIL directed w0: got %0d/%h need 0/00000013", obs_addr[0], obs_data[0]); end
      if (obs_addr[1] != 1 || obs_data[1] !== 32'h0010_0093) begin errors++; $display("FAIL directed w1: got %0d/%h need 1/00100093", obs_addr[1], obs_data[1]); end
      if (obs_hold[1] !== 1'b1) begin errors++; $display("FAIL directed hold at last write: got %b need 1", obs_hold[1]); end
    end
    if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0) begin errors++; $display("FAIL directed status: got done=%b err=%b need 1/0", bus.load_done, bus.load_error); end
    if (bus.cpu_rst_hold !== 1'b0) begin errors++; $display("FAIL directed hold: got %b need 0", bus.cpu_rst_hold); end
    if (bus.byte_ready !== 1'b0)   begin errors++; $display("FAIL directed ready in done: got %b need 0", bus.byte_ready); end
    // Bytes offered in DONE must be ignored.
    @(negedge clk); bus.byte_valid = 1; bus.byte_data = 8'hAA;
    repeat (6) @(negedge clk);
    bus.byte_valid = 0;
    checks++;
    if (obs_addr.size() != 2 || bus.load_done !== 1'b1) begin errors++; $display("FAIL done ignores bytes: got %0d writes done=%b need 2/1", obs_addr.size(), bus.load_done); end
  endtask

  task automatic test_zero();
    do_reset();
    start_prog(0); add_csum();
    send_prog(prog.size(), 0);
    checks += 2;
    if (obs_addr.size() != 0) begin errors++; $display("FAIL zero writes: got %0d need 0", obs_addr.size()); end
    if (bus.load_done !== 1'b1 || bus.cpu_rst_hold !== 1'b0) begin errors++; $display("FAIL zero status: got done=%b hold=%b need 1/0", bus.load_done, bus.cpu_rst_hold); end
  endtask

  task automatic test_oversize();
    do_reset();
    start_prog(32'd1025);
    send_prog(prog.size(), 0);
    checks += 3;
    if (bus.load_error !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("FAIL oversize status: got err=%b done=%b need 1/0", bus.load_error, bus.load_done); end
    if (bus.byte_ready !== 1'b0 || bus.cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL oversize ready/hold: got %b/%b need 0/1", bus.byte_ready, bus.cpu_rst_hold); end
    if (obs_addr.size() != 0) begin errors++; $display("FAIL oversize writes: got %0d need 0", obs_addr.size()); end
  endtask

  task automatic test_rst_midload();
    logic [31:0] w;
    do_reset();
    start_prog(2); push_data(32'h1111_2222); push_data(32'h3333_4444);
    send_prog(10, 0);
    do_reset();
    w = $urandom;
    start_prog(1); push_data(w); add_csum();
    send_prog(prog.size(), 1);
    checks += 2;
    if (obs_addr.size() != 1 || obs_addr[0] != 0 || obs_data[0] !== w) begin
      errors++;
      $display("FAIL rst_midload write: got %0d writes first %h need 1 write addr 0 data %h",
               obs_addr.size(), (obs_data.size() > 0) ? obs_data[0] : 32'h0, w);
    end
    if (bus.load_done !== 1'b1) begin errors++; $display("FAIL rst_midload done: got %b need 1", bus.load_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_prog(3);
    for (int k = 0; k < 3; k++) push_data($urandom);
    add_csum();
    model();
    send_prog(prog.size(), 0);
    checks++;
    if (obs_addr.size() != 3) begin
      errors++; $display("FAIL b2b count: got %0d need 3", obs_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL b2b write %0d: got %0d/%h need %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_cyc[i+1] - obs_cyc[i] != 4) begin errors++; $display("FAIL b2b spacing %0d: got %0d cycles need 4", i, obs_cyc[i+1] - obs_cyc[i]); end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n = $urandom_range(1, 6);
      bit bad = 0;
      do_reset();
      start_prog(n);
      for (int k = 0; k < n; k++) push_data($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`endif
      if (bad) add_bad_csum(); else add_csum();
      model();
      send_prog(prog.size(), 3);
      checks += 3;
      if (obs_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL random[%0d] count: got %0d need %0d", it, obs_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          checks++;
          if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin errors++; $display("FAIL random[%0d] write %0d: got %0d/%h need %0d/%h", it, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
        end
      end
      if (bus.load_done !== exp_done || bus.load_error !== exp_err) begin errors++; $display("FAIL random[%0d] status: got done=%b err=%b need %b/%b", it, bus.load_done, bus.load_error, exp_done, exp_err); end
      if (bus.cpu_rst_hold !== !exp_done || bus.byte_ready !== 1'b0) begin errors++; $display("FAIL random[%0d] hold/ready: got %b/%b need %b/0", it, bus.cpu_rst_hold, bus.byte_ready, !exp_done); end
    end
  endtask

  task automatic test_max_words();
    int bad = 0;
    do_reset();
    start_prog(MAXW);
    for (int k = 0; k < MAXW; k++) push_data($urandom);
    add_csum();
    model();
    send_prog(prog.size(), 0);
    checks += 3;
    if (obs_addr.size() != MAXW) begin
      errors++; $display("FAIL max count: got %0d need %0d", obs_addr.size(), MAXW);
    end else begin
      for (int i = 0; i < MAXW; i++)
        if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
      if (bad != 0) begin errors++; $display("FAIL max contents: got %0d wrong writes need 0", bad); end
    end
    if (bus.load_done !== 1'b1) begin errors++; $display("FAIL max done: got %b need 1", bus.load_done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_csum();
    do_reset();
    prog.delete();
    push_word(2); push_word(32'h0000_0013); push_word(32'h0010_0093); push_word(32'h0010_00A7);
    send_prog(prog.size(), 0);
    checks += 2;
    if (bus.load_error !== 1'b1 || bus.load_done !== 1'b0) begin errors++; $display("FAIL csum bad status: got err=%b done=%b need 1/0", bus.load_error, bus.load_done); end
    if (bus.cpu_rst_hold !== 1'b1) begin errors++; $display("FAIL csum bad hold: got %b need 1", bus.cpu_rst_hold); end
  endtask
`endif

  initial begin
    rst = 1; bus.byte_valid = 0; bus.byte_data = 0;
    test_reset();
    test_directed();
    test_zero();
    test_oversize();
    test_rst_midload();
    test_back_to_back();
    test_random();
    test_max_words();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_csum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
